pn_iq_spreader: RTL

PN_IQ_SPREADER -- requirements
Module: pn_iq_spreader

---
 rtl/pn_iq_spreader.sv | 118 +++++++++++
 1 files changed

// File: rtl/pn_iq_spreader.sv
// PN-spreads one I/Q data bit pair per symbol into CHIPS bipolar chips using an
// x^9+x^5+1 LFSR reloaded to SEED at every symbol start; all chip outputs registered.
module pn_iq_spreader #(
  parameter int         CHIPS = 496,
  parameter logic [8:0] SEED  = 9'h1FF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_valid,
  input  logic        data_i,
  input  logic        data_q,
  input  logic        abort,
  output logic        data_ready,
  output logic [1:0]  I_out,
  output logic [1:0]  Q_out,
  output logic        chip_valid,
  output logic        frame_start,
  output logic [15:0] sym_count
);

  localparam logic       ST_IDLE = 1'b0;
  localparam logic       ST_SEND = 1'b1;
  localparam logic [8:0] LAST    = 9'(CHIPS - 1);

  logic        state_q, state_d;
  logic [8:0]  cnt_q, cnt_d;
  logic [8:0]  lfsr_q, lfsr_d, lfsr_adv, chip_lfsr;
  logic        di_q, di_d, dq_q, dq_d, chip_di, chip_dq;
  logic [1:0]  i_q, i_d, q_q, q_d;
  logic        cv_q, cv_d, fs_q, fs_d;
  logic [15:0] sym_q, sym_d;
  logic        last, accept, emit;

  always_comb begin
    last       = (state_q == ST_SEND) && (cnt_q == LAST);
    data_ready = !rst && !abort && ((state_q == ST_IDLE) || last);
    accept     = data_valid && data_ready;
    lfsr_adv   = {lfsr_q[7:0], lfsr_q[8] ^ lfsr_q[4]};

    state_d   = state_q;
    cnt_d     = cnt_q;
    lfsr_d    = lfsr_q;
    di_d      = di_q;
    dq_d      = dq_q;
    sym_d     = sym_q;
    fs_d      = 1'b0;
    emit      = 1'b0;
    chip_lfsr = lfsr_adv;
    chip_di   = di_q;
    chip_dq   = dq_q;

    // The last chip has already been shown when abort arrives, but the symbol
    // is still treated as partial and not counted.
    if (last && !abort) sym_d = sym_q + 16'd1;

    if (abort) begin
      state_d = ST_IDLE;
    end else if (accept) begin
      state_d   = ST_SEND;
      cnt_d     = 9'd0;
      lfsr_d    = SEED;
      di_d      = data_i;
      dq_d      = data_q;
      chip_lfsr = SEED;
      chip_di   = data_i;
      chip_dq   = data_q;
      fs_d      = 1'b1;
      emit      = 1'b1;
    end else if (last) begin
      state_d = ST_IDLE;
    end else if (state_q == ST_SEND) begin
      cnt_d  = cnt_q + 9'd1;
      lfsr_d = lfsr_adv;
      emit   = 1'b1;
    end

    cv_d = emit;
    i_d  = 2'b00;
    q_d  = 2'b00;
    if (emit) begin
      i_d = (chip_di ^ chip_lfsr[0]) ? 2'b11 : 2'b01;
      q_d = (chip_dq ^ chip_lfsr[4]) ? 2'b11 : 2'b01;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 9'd0;
      lfsr_q  <= SEED;
      di_q    <= 1'b0;
      dq_q    <= 1'b0;
      i_q     <= 2'b00;
      q_q     <= 2'b00;
      cv_q    <= 1'b0;
      fs_q    <= 1'b0;
      sym_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lfsr_q  <= lfsr_d;
      di_q    <= di_d;
      dq_q    <= dq_d;
      i_q     <= i_d;
      q_q     <= q_d;
      cv_q    <= cv_d;
      fs_q    <= fs_d;
      sym_q   <= sym_d;
    end
  end

  assign I_out       = i_q;
  assign Q_out       = q_q;
  assign chip_valid  = cv_q;
  assign frame_start = fs_q;
  assign sym_count   = sym_q;

endmodule
